// File: rtl/readout_tx_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// readout_tx_pulse_sequencer
//
// Purpose:
//   Generates one shaped readout-transmit pulse per measurement request.
//   The pulse is a stream of (amplitude, carrier phase) samples:
//     ramp-up  : ramp_mem[0 .. RAMP_LEN-1]
//     hold     : amp_hold, up to MAX_TRIAL trials of STEP_LIMIT_THRESHOLD
//                samples each, or cut short by stop_meas
//     ramp-down: ramp_mem[RAMP_LEN-1 .. 0]
//   followed by a single DONE cycle that reports how many trials were begun.
//   The carrier phase starts at 0 on the first sample and advances by the
//   programmed frequency word on every valid sample.
//
// Configuration:
//   READOUT_TX_RAMP_EN  defined   -> ramp memory and ramp-up/ramp-down present
//                       undefined -> no ramp memory, ramp_wr_* are ignored,
//                                    the pulse is the hold section only
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   freq_wr_en/_data    phase increment write (ignored while busy)
//   amp_wr_en/_data     hold amplitude write (ignored while busy)
//   ramp_wr_en/_addr/_data  ramp memory write (ignored while busy)
//   start_meas          measurement request, accepted only when idle
//   stop_meas           early stop, honoured only during the hold section
//   busy_out            high while a measurement is in progress
//   valid_out           sample valid; amp_out/phase_out are 0 when low
//   amp_out, phase_out  envelope amplitude and carrier phase
//   start_count_out     pulse with the first hold sample
//   finish_count_out    pulse with the last hold sample
//   done_out            pulse, measurement complete
//   trials_used_out     trials begun, valid together with done_out
// -----------------------------------------------------------------------------
module readout_tx_pulse_sequencer #(
  parameter int DATA_WIDTH           = 16,
  parameter int PHASE_WIDTH          = 16,
  parameter int RAMP_LEN             = 8,
  parameter int RAMP_ADDR_WIDTH      = 3,
  parameter int STEP_LIMIT_THRESHOLD = 125,
  parameter int MAX_TRIAL            = 10,
  parameter int STEP_COUNTER_WIDTH   = 8,
  parameter int TRIAL_COUNTER_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freq_wr_en,
  input  logic [PHASE_WIDTH-1:0]         freq_wr_data,
  input  logic                           amp_wr_en,
  input  logic [DATA_WIDTH-1:0]          amp_wr_data,
  input  logic                           ramp_wr_en,
  input  logic [RAMP_ADDR_WIDTH-1:0]     ramp_wr_addr,
  input  logic [DATA_WIDTH-1:0]          ramp_wr_data,
  input  logic                           start_meas,
  input  logic                           stop_meas,
  output logic                           busy_out,
  output logic                           valid_out,
  output logic [DATA_WIDTH-1:0]          amp_out,
  output logic [PHASE_WIDTH-1:0]         phase_out,
  output logic                           start_count_out,
  output logic                           finish_count_out,
  output logic                           done_out,
  output logic [TRIAL_COUNTER_WIDTH-1:0] trials_used_out
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN,
    DONE
  } state_t;

  localparam logic [STEP_COUNTER_WIDTH-1:0]  STEP_LAST  = STEP_COUNTER_WIDTH'(STEP_LIMIT_THRESHOLD - 1);
  localparam logic [TRIAL_COUNTER_WIDTH-1:0] TRIAL_LAST = TRIAL_COUNTER_WIDTH'(MAX_TRIAL - 1);
  localparam logic [TRIAL_COUNTER_WIDTH-1:0] TRIAL_MAX  = TRIAL_COUNTER_WIDTH'(MAX_TRIAL);
  // With a one-sample hold section the very first hold sample is also the last.
  localparam logic SINGLE_SAMPLE = (MAX_TRIAL * STEP_LIMIT_THRESHOLD == 1);

  state_t                         state;
  logic [PHASE_WIDTH-1:0]         freq_word;
  logic [DATA_WIDTH-1:0]          amp_hold;
  // Phase that the next emitted sample will carry.
  logic [PHASE_WIDTH-1:0]         phase_acc;
  // Step/trial position of the hold sample currently on the outputs.
  logic [STEP_COUNTER_WIDTH-1:0]  step_cnt;
  logic [TRIAL_COUNTER_WIDTH-1:0] trial_cnt;

  logic [STEP_COUNTER_WIDTH-1:0]  step_next;
  logic [TRIAL_COUNTER_WIDTH-1:0] trial_next;
  logic [TRIAL_COUNTER_WIDTH-1:0] trials_report;
  logic                           next_is_last;

`ifdef READOUT_TX_RAMP_EN
  localparam logic [RAMP_ADDR_WIDTH-1:0] RAMP_LAST = RAMP_ADDR_WIDTH'(RAMP_LEN - 1);
  logic [DATA_WIDTH-1:0]      ramp_mem [RAMP_LEN];
  // Index of the ramp entry currently on the outputs.
  logic [RAMP_ADDR_WIDTH-1:0] ramp_idx;
`else
  localparam int UNUSED_RAMP_LEN = RAMP_LEN;
  logic unused_ramp_wr;
  assign unused_ramp_wr = ^{ramp_wr_en, ramp_wr_addr, ramp_wr_data};
`endif

  // Position of the following hold sample, whether that sample is the
  // natural end of the hold section, and the trial count reported at DONE
  // (index of the trial in which the hold section ended, plus one, saturated).
  always_comb begin
    step_next  = step_cnt + 1'b1;
    trial_next = trial_cnt;
    if (step_cnt == STEP_LAST) begin
      step_next  = '0;
      trial_next = trial_cnt + 1'b1;
    end
    next_is_last  = (trial_next == TRIAL_LAST) && (step_next == STEP_LAST);
    trials_report = (trial_cnt >= TRIAL_LAST) ? TRIAL_MAX : trial_cnt + 1'b1;
  end

  // Single sequencer process. Every output is a register that holds the
  // sample currently being presented; each clock edge decides the next sample
  // from the present state. Configuration writes are only taken while idle so
  // a running pulse can never change shape half way through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      freq_word        <= '0;
      amp_hold         <= '0;
      phase_acc        <= '0;
      step_cnt         <= '0;
      trial_cnt        <= '0;
      busy_out         <= 1'b0;
      valid_out        <= 1'b0;
      amp_out          <= '0;
      phase_out        <= '0;
      start_count_out  <= 1'b0;
      finish_count_out <= 1'b0;
      done_out         <= 1'b0;
      trials_used_out  <= '0;
`ifdef READOUT_TX_RAMP_EN
      ramp_idx         <= '0;
      for (int i = 0; i < RAMP_LEN; i++) begin
        ramp_mem[i] <= '0;
      end
`endif
    end else begin
      start_count_out <= 1'b0;
      done_out        <= 1'b0;

      if (!busy_out) begin
        if (freq_wr_en) freq_word <= freq_wr_data;
        if (amp_wr_en)  amp_hold  <= amp_wr_data;
`ifdef READOUT_TX_RAMP_EN
        if (ramp_wr_en) ramp_mem[ramp_wr_addr] <= ramp_wr_data;
`endif
      end

      case (state)
        IDLE: begin
          if (start_meas) begin
            busy_out  <= 1'b1;
            valid_out <= 1'b1;
            phase_out <= '0;
            phase_acc <= freq_word;
            step_cnt  <= '0;
            trial_cnt <= '0;
`ifdef READOUT_TX_RAMP_EN
            state            <= RAMP_UP;
            amp_out          <= ramp_mem[0];
            ramp_idx         <= '0;
            finish_count_out <= 1'b0;
`else
            state            <= HOLD;
            amp_out          <= amp_hold;
            start_count_out  <= 1'b1;
            finish_count_out <= SINGLE_SAMPLE;
`endif
          end
        end

`ifdef READOUT_TX_RAMP_EN
        RAMP_UP: begin
          phase_out <= phase_acc;
          phase_acc <= phase_acc + freq_word;
          if (ramp_idx == RAMP_LAST) begin
            state            <= HOLD;
            amp_out          <= amp_hold;
            start_count_out  <= 1'b1;
            finish_count_out <= SINGLE_SAMPLE;
          end else begin
            ramp_idx <= ramp_idx + 1'b1;
            amp_out  <= ramp_mem[ramp_idx + 1'b1];
          end
        end
`endif

        HOLD: begin
          if (finish_count_out) begin
            // The sample on the outputs closed the hold section; trial_cnt is
            // frozen from here on so DONE can report it.
            finish_count_out <= 1'b0;
`ifdef READOUT_TX_RAMP_EN
            state     <= RAMP_DOWN;
            amp_out   <= ramp_mem[RAMP_LAST];
            ramp_idx  <= RAMP_LAST;
            phase_out <= phase_acc;
            phase_acc <= phase_acc + freq_word;
`else
            state           <= DONE;
            valid_out       <= 1'b0;
            amp_out         <= '0;
            phase_out       <= '0;
            done_out        <= 1'b1;
            trials_used_out <= trials_report;
`endif
          end else begin
            // stop_meas seen while launching a hold sample marks that sample
            // as the last one; if it coincides with the natural end the two
            // simply merge into the same flag.
            step_cnt         <= step_next;
            trial_cnt        <= trial_next;
            phase_out        <= phase_acc;
            phase_acc        <= phase_acc + freq_word;
            finish_count_out <= stop_meas || next_is_last;
          end
        end

`ifdef READOUT_TX_RAMP_EN
        RAMP_DOWN: begin
          if (ramp_idx == '0) begin
            state           <= DONE;
            valid_out       <= 1'b0;
            amp_out         <= '0;
            phase_out       <= '0;
            done_out        <= 1'b1;
            trials_used_out <= trials_report;
          end else begin
            ramp_idx  <= ramp_idx - 1'b1;
            amp_out   <= ramp_mem[ramp_idx - 1'b1];
            phase_out <= phase_acc;
            phase_acc <= phase_acc + freq_word;
          end
        end
`endif

        DONE: begin
          state           <= IDLE;
          busy_out        <= 1'b0;
          trials_used_out <= '0;
        end

        default: begin
          state     <= IDLE;
          busy_out  <= 1'b0;
          valid_out <= 1'b0;
          amp_out   <= '0;
          phase_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_tx_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_readout_tx_pulse_sequencer
//
// Purpose:
//   Self-checking bench for readout_tx_pulse_sequencer with RAMP_LEN 2,
//   STEP_LIMIT_THRESHOLD 4 and MAX_TRIAL 2. A model builds the expected
//   sample-by-sample pulse from the programmed values and the stop point;
//   one compare process checks the DUT against it every cycle. Works with
//   READOUT_TX_RAMP_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_readout_tx_pulse_sequencer;

  localparam int DW  = 16;
  localparam int PW  = 16;
  localparam int RL  = 2;
  localparam int ST  = 4;
  localparam int MT  = 2;
  localparam int TCW = 4;

`ifdef READOUT_TX_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
  localparam int L19 = 12;
  localparam int L20 = 6;
  localparam int LAST_PHASE19 = 33;
  int lit19 [L19] = '{10, 20, 50, 50, 50, 50, 50, 50, 50, 50, 20, 10};
  int lit20 [L20] = '{10, 20, 50, 50, 20, 10};
`else
  localparam bit RAMP_EN = 1'b0;
  localparam int L19 = 8;
  localparam int L20 = 2;
  localparam int LAST_PHASE19 = 21;
  int lit19 [L19] = '{50, 50, 50, 50, 50, 50, 50, 50};
  int lit20 [L20] = '{50, 50};
`endif
  localparam int RAMP_SAMPLES = RAMP_EN ? RL : 0;

  logic           clk;
  logic           rst;
  logic           freq_wr_en;
  logic [PW-1:0]  freq_wr_data;
  logic           amp_wr_en;
  logic [DW-1:0]  amp_wr_data;
  logic           ramp_wr_en;
  logic [0:0]     ramp_wr_addr;
  logic [DW-1:0]  ramp_wr_data;
  logic           start_meas;
  logic           stop_meas;
  logic           busy_out;
  logic           valid_out;
  logic [DW-1:0]  amp_out;
  logic [PW-1:0]  phase_out;
  logic           start_count_out;
  logic           finish_count_out;
  logic           done_out;
  logic [TCW-1:0] trials_used_out;

  readout_tx_pulse_sequencer #(
    .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .RAMP_LEN(RL), .RAMP_ADDR_WIDTH(1),
    .STEP_LIMIT_THRESHOLD(ST), .MAX_TRIAL(MT),
    .STEP_COUNTER_WIDTH(8), .TRIAL_COUNTER_WIDTH(TCW)
  ) dut (
    .clk(clk), .rst(rst),
    .freq_wr_en(freq_wr_en), .freq_wr_data(freq_wr_data),
    .amp_wr_en(amp_wr_en), .amp_wr_data(amp_wr_data),
    .ramp_wr_en(ramp_wr_en), .ramp_wr_addr(ramp_wr_addr), .ramp_wr_data(ramp_wr_data),
    .start_meas(start_meas), .stop_meas(stop_meas),
    .busy_out(busy_out), .valid_out(valid_out),
    .amp_out(amp_out), .phase_out(phase_out),
    .start_count_out(start_count_out), .finish_count_out(finish_count_out),
    .done_out(done_out), .trials_used_out(trials_used_out)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          busy;
    logic          valid;
    logic [DW-1:0] amp;
    logic [PW-1:0] phase;
    logic          sc;
    logic          fc;
    logic          done;
    logic [3:0]    trials;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur_exp;
  int   errors = 0;
  int   checks = 0;
  bit   check_en = 1'b0;
  int   done_idx;

  logic [PW-1:0] model_freq;
  logic [DW-1:0] model_amp;
  logic [DW-1:0] model_ramp [RL];

  int obs_amp [$];
  int obs_phase [$];
  int fc_count;
  int last_trials;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pulse for the current programming: ramp-up, n_hold hold samples,
  // ramp-down, DONE, then one idle cycle. stop_n is the hold sample (1-based)
  // on which stop_meas is raised; 0 means run to the natural end.
  task automatic build_model(input int stop_n);
    int   n_hold;
    int   k;
    exp_t e;
    n_hold = (stop_n >= 2 && stop_n < MT * ST) ? stop_n : MT * ST;
    exp_q.delete();
    k = 0;
    e = '{busy: 1'b1, valid: 1'b1, amp: '0, phase: '0, sc: 1'b0, fc: 1'b0, done: 1'b0, trials: '0};
    if (RAMP_EN) begin
      for (int i = 0; i < RL; i++) begin
        e.amp = model_ramp[i]; e.phase = 16'(k * int'(model_freq)); k++;
        exp_q.push_back(e);
      end
    end
    for (int i = 1; i <= n_hold; i++) begin
      e.amp = model_amp; e.phase = 16'(k * int'(model_freq)); k++;
      e.sc = (i == 1); e.fc = (i == n_hold);
      exp_q.push_back(e);
    end
    e.sc = 1'b0; e.fc = 1'b0;
    if (RAMP_EN) begin
      for (int i = RL - 1; i >= 0; i--) begin
        e.amp = model_ramp[i]; e.phase = 16'(k * int'(model_freq)); k++;
        exp_q.push_back(e);
      end
    end
    e.valid = 1'b0; e.amp = '0; e.phase = '0; e.done = 1'b1;
    e.trials = 4'(((n_hold - 1) / ST + 1 > MT) ? MT : (n_hold - 1) / ST + 1);
    exp_q.push_back(e);
    done_idx = exp_q.size() - 1;
    e.busy = 1'b0; e.done = 1'b0; e.trials = '0;
    exp_q.push_back(e);
  endtask

  // Writes freq, hold amplitude and both ramp entries while idle.
  task automatic program_regs(input logic [PW-1:0] f, input logic [DW-1:0] a,
                              input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    freq_wr_en = 1'b1; freq_wr_data = f;
    amp_wr_en  = 1'b1; amp_wr_data  = a;
    ramp_wr_en = 1'b1; ramp_wr_addr = 1'b0; ramp_wr_data = r0;
    @(posedge clk); #2;
    freq_wr_en = 1'b0; amp_wr_en = 1'b0;
    ramp_wr_addr = 1'b1; ramp_wr_data = r1;
    @(posedge clk); #2;
    ramp_wr_en = 1'b0;
    model_freq = f; model_amp = a; model_ramp[0] = r0; model_ramp[1] = r1;
  endtask

  // Runs one measurement. Loop iteration c happens while sample c is on the
  // outputs, so inputs set there are seen by the edge launching sample c+1.
  // poke_c >= 0 issues a restart plus config writes at that cycle; stray
  // raises stop_meas while idle before the start and during the DONE cycle.
  task automatic applyStimulus(input int stop_n, input int poke_c, input bit stray);
    int c;
    build_model(stop_n);
    obs_amp.delete(); obs_phase.delete(); fc_count = 0; last_trials = -1;
    if (stray) begin
      stop_meas = 1'b1;
      @(posedge clk); #2;
      stop_meas = 1'b0;
    end
    start_meas = 1'b1;
    @(posedge clk); #2;
    start_meas = 1'b0;
    check_en = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 200) begin
      stop_meas  = (stop_n >= 2 && c == RAMP_SAMPLES + stop_n - 2) || (stray && c == done_idx);
      start_meas = (c == poke_c);
      amp_wr_en  = (c == poke_c); amp_wr_data  = 16'd99;
      freq_wr_en = (c == poke_c); freq_wr_data = 16'd7;
      ramp_wr_en = (c == poke_c); ramp_wr_addr = 1'b0; ramp_wr_data = 16'd77;
      @(posedge clk); #2;
      c++;
    end
    stop_meas = 1'b0; start_meas = 1'b0;
    amp_wr_en = 1'b0; freq_wr_en = 1'b0; ramp_wr_en = 1'b0;
    check_en = 1'b0;
    checkOutput("meas_timeout_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Compare process: one expected entry per cycle while a run is active.
  always @(negedge clk) begin
    if (check_en && exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      checkOutput("busy_out", 32'(busy_out), 32'(cur_exp.busy));
      checkOutput("valid_out", 32'(valid_out), 32'(cur_exp.valid));
      checkOutput("amp_out", 32'(amp_out), 32'(cur_exp.amp));
      checkOutput("phase_out", 32'(phase_out), 32'(cur_exp.phase));
      checkOutput("start_count_out", 32'(start_count_out), 32'(cur_exp.sc));
      checkOutput("finish_count_out", 32'(finish_count_out), 32'(cur_exp.fc));
      checkOutput("done_out", 32'(done_out), 32'(cur_exp.done));
      if (cur_exp.done) checkOutput("trials_used_out", 32'(trials_used_out), 32'(cur_exp.trials));
      if (valid_out) begin
        obs_amp.push_back(int'(amp_out));
        obs_phase.push_back(int'(phase_out));
      end
      if (finish_count_out) fc_count++;
      if (done_out) last_trials = int'(trials_used_out);
    end
  end

  initial begin
    rst = 1'b0;
    freq_wr_en = 1'b0; freq_wr_data = '0;
    amp_wr_en = 1'b0;  amp_wr_data = '0;
    ramp_wr_en = 1'b0; ramp_wr_addr = '0; ramp_wr_data = '0;
    start_meas = 1'b0; stop_meas = 1'b0;
    model_freq = '0; model_amp = '0; model_ramp[0] = '0; model_ramp[1] = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_busy", 32'(busy_out), 32'd0);
    checkOutput("reset_valid", 32'(valid_out), 32'd0);
    checkOutput("reset_amp", 32'(amp_out), 32'd0);
    checkOutput("reset_phase", 32'(phase_out), 32'd0);
    checkOutput("reset_done", 32'(done_out), 32'd0);
    @(posedge clk); #2;

    // Natural end: ramp {10,20}, amp 50, freq 3.
    program_regs(16'd3, 16'd50, 16'd10, 16'd20);
    applyStimulus(0, -1, 1'b0);
    checkOutput("pin19_len", 32'(obs_amp.size()), 32'(L19));
    for (int i = 0; i < L19 && i < obs_amp.size(); i++)
      checkOutput("pin19_amp", 32'(obs_amp[i]), 32'(lit19[i]));
    if (obs_phase.size() > 0)
      checkOutput("pin19_last_phase", 32'(obs_phase[obs_phase.size() - 1]), 32'(LAST_PHASE19));
    checkOutput("pin19_fc_count", 32'(fc_count), 32'd1);
    checkOutput("pin19_trials", 32'(last_trials), 32'd2);

    // Stop on 2nd hold sample, stray stops while idle/DONE, restart and
    // config writes while busy.
    applyStimulus(2, RAMP_SAMPLES, 1'b1);
    checkOutput("pin20_len", 32'(obs_amp.size()), 32'(L20));
    for (int i = 0; i < L20 && i < obs_amp.size(); i++)
      checkOutput("pin20_amp", 32'(obs_amp[i]), 32'(lit20[i]));
    checkOutput("pin20_trials", 32'(last_trials), 32'd1);

    // Stop coinciding with the natural end; config must be unchanged.
    applyStimulus(8, -1, 1'b0);
    checkOutput("pin21_fc_count", 32'(fc_count), 32'd1);
    checkOutput("pin21_trials", 32'(last_trials), 32'd2);
    if (obs_amp.size() > RAMP_SAMPLES)
      checkOutput("pin22_amp_kept", 32'(obs_amp[RAMP_SAMPLES]), 32'd50);

    // Phase wrap and stop in the second trial.
    program_regs(16'h7000, 16'hBEEF, 16'd1, 16'hFFFF);
    applyStimulus(5, -1, 1'b0);
    if (obs_phase.size() > 3)
      checkOutput("pin_phase_wrap", 32'(obs_phase[3]), 32'h5000);
    checkOutput("pin_stop5_trials", 32'(last_trials), 32'd2);

    // Reset in the middle of the hold section.
    program_regs(16'd3, 16'd50, 16'd10, 16'd20);
    start_meas = 1'b1;
    @(posedge clk); #2;
    start_meas = 1'b0;
    repeat (RAMP_SAMPLES + 2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy_out), 32'd0);
    checkOutput("midrst_valid", 32'(valid_out), 32'd0);
    checkOutput("midrst_amp", 32'(amp_out), 32'd0);
    checkOutput("midrst_phase", 32'(phase_out), 32'd0);
    checkOutput("midrst_sc_fc", 32'({start_count_out, finish_count_out}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 32'(done_out), 32'd0);
    end
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("postrst_no_done", 32'(done_out), 32'd0);
    end
    @(posedge clk); #2;
    model_freq = '0; model_amp = '0; model_ramp[0] = '0; model_ramp[1] = '0;
    applyStimulus(0, -1, 1'b0);
    if (obs_amp.size() > RAMP_SAMPLES)
      checkOutput("pin23_amp_zero", 32'(obs_amp[RAMP_SAMPLES]), 32'd0);
    if (obs_phase.size() > 0)
      checkOutput("pin23_phase_zero", 32'(obs_phase[obs_phase.size() - 1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/readout_tx_pulse_sequencer.md
READOUT_TX_PULSE_SEQUENCER -- requirements
Module: readout_tx_pulse_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 16, sample/amplitude width; PHASE_WIDTH 16, phase accumulator width; RAMP_LEN 8, ramp memory depth; RAMP_ADDR_WIDTH 3, ramp address width; STEP_LIMIT_THRESHOLD 125, HOLD cycles per trial; MAX_TRIAL 10, maximum trials; STEP_COUNTER_WIDTH 8; TRIAL_COUNTER_WIDTH 4.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
freq_wr_en  in  1  frequency-word write strobe
freq_wr_data  in  PHASE_WIDTH  phase increment
amp_wr_en  in  1  hold-amplitude write strobe
amp_wr_data  in  DATA_WIDTH  hold amplitude
ramp_wr_en  in  1  ramp memory write strobe
ramp_wr_addr  in  RAMP_ADDR_WIDTH  ramp entry index
ramp_wr_data  in  DATA_WIDTH  ramp amplitude
start_meas  in  1  measurement request pulse
stop_meas  in  1  early stop from the receive-side decision
busy_out  out  1  high while not IDLE
valid_out  out  1  sample valid
amp_out  out  DATA_WIDTH  envelope amplitude
phase_out  out  PHASE_WIDTH  carrier phase
start_count_out  out  1  pulse, first HOLD sample
finish_count_out  out  1  pulse, last HOLD sample
done_out  out  1  pulse, measurement complete
trials_used_out  out  TRIAL_COUNTER_WIDTH  trials begun, valid with done_out

Function
REQ-003 SHALL use FSM states IDLE, RAMP_UP, HOLD, RAMP_DOWN, DONE; all outputs registered.
REQ-004 SHALL accept start_meas only in IDLE; start_meas is ignored in all other states.
REQ-005 SHALL, on acceptance, clear the phase accumulator, step counter and trial counter, and enter RAMP_UP; the first valid sample appears the next cycle.
REQ-006 RAMP_UP SHALL last RAMP_LEN cycles, with amp_out = ramp_mem[0..RAMP_LEN-1] in ascending order.
REQ-007 HOLD SHALL output amp_out = amp_hold; the step counter counts 0..STEP_LIMIT_THRESHOLD-1; on wrap the trial counter increments.
REQ-008 start_count_out SHALL pulse with the first HOLD sample only.
REQ-009 HOLD SHALL end after MAX_TRIAL*STEP_LIMIT_THRESHOLD samples, or on the HOLD sample during which stop_meas is sampled high; that sample carries finish_count_out; simultaneous stop and natural end give one pulse.
REQ-010 stop_meas outside HOLD SHALL be ignored.
REQ-011 RAMP_DOWN SHALL last RAMP_LEN cycles, with amp_out = ramp_mem[RAMP_LEN-1..0] in descending order.
REQ-012 DONE SHALL last one cycle: valid_out=0, done_out=1, trials_used_out = trial index at stop + 1 (saturating at MAX_TRIAL); then return to IDLE.
REQ-013 phase_out SHALL be 0 on the first sample and increase by freq each valid sample, modulo 2^PHASE_WIDTH.
REQ-014 valid_out SHALL be 1 exactly in RAMP_UP, HOLD and RAMP_DOWN; when valid_out=0, amp_out and phase_out = 0.
REQ-015 freq/amp/ramp writes SHALL be ignored while busy_out=1.

Reset
REQ-016 rst low SHALL asynchronously force IDLE, clear all counters, outputs, freq, amp_hold and ramp_mem to 0, including mid-measurement; no done_out results.

Configuration
REQ-017 READOUT_TX_RAMP_EN defined: ramp memory and the RAMP_UP/RAMP_DOWN states are present per REQ-006/011.
REQ-018 READOUT_TX_RAMP_EN undefined: no ramp memory; ramp_wr_* are ignored; acceptance goes directly to HOLD (first sample next cycle) and HOLD goes directly to DONE.

Verification (RAMP_LEN 2, STEP_LIMIT_THRESHOLD 4, MAX_TRIAL 2, macro defined unless noted)
REQ-019 ramp={10,20}, amp=50, freq=3, start -> amp 10,20,50x8,20,10; phase 0,3..33; start_count on the 3rd sample, finish_count on the 10th; done with trials=2.
REQ-020 stop_meas on the 2nd HOLD sample -> finish_count on that sample, RAMP_DOWN 20,10, done with trials=1.
REQ-021 stop_meas on the 8th HOLD sample -> a single finish_count pulse, trials=2.
REQ-022 start_meas during HOLD and amp write while busy -> no restart, amplitude unchanged.
REQ-023 rst low during HOLD -> outputs 0 immediately; no done_out; next start_meas uses amp=0, freq=0.
REQ-024 Macro undefined, same stimulus as REQ-019 -> 8 samples of 50, done with trials=2.
